// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int          NIBBLES  = 4;
    localparam logic [1:0]  LAST_NIB = 2'(NIBBLES - 1);
    localparam logic [15:0] SAT_MAX  = 16'h7FFF;
    localparam logic [15:0] SAT_MIN  = 16'h8000;

endpackage

// File: rtl/CLA_4bit_AddSub.sv
// 4-bit carry-lookahead add/subtract slice; G is the group carry-out including the Cin term.
module CLA_4bit_AddSub (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       sub,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       G
);

    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign bx = B ^ {4{sub}};
    assign g  = A & bx;
    assign p  = A ^ bx;

    // Flattened lookahead terms so no carry ripples through the slice.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign S = p ^ c[3:0];
    assign G = c[4];

endmodule

// File: rtl/nibble_addsub_seq.sv
// 16-bit add/sub computed one nibble per cycle through a shared 4-bit CLA slice.
// Optional saturation on signed overflow: define NIBBLE_ADDSUB_SATURATE_EN.
module nibble_addsub_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] S,
    output logic        ovfl,
    output logic        zero
);

    seq_state_t  state_q;
    logic [15:0] a_q;
    logic [15:0] beff_q;
    logic [11:0] partial_q;
    logic        carry_q;
    logic [1:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] s_q;
    logic        ovfl_q;
    logic        zero_q;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_s;
    logic        nib_c;
    logic [15:0] raw;
    logic [15:0] s_d;
    logic        ovfl_d;
    logic        zero_d;

    // Slice inputs come only from captured registers; start never reaches the slice.
    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign nib_b = beff_q[{cnt_q, 2'b00} +: 4];

    CLA_4bit_AddSub u_slice (
        .A   (nib_a),
        .B   (nib_b),
        .sub (1'b0),
        .Cin (carry_q),
        .S   (nib_s),
        .G   (nib_c)
    );

    assign raw    = {nib_s, partial_q};
    assign ovfl_d = (a_q[15] == beff_q[15]) && (raw[15] != a_q[15]);
`ifdef NIBBLE_ADDSUB_SATURATE_EN
    assign s_d    = ovfl_d ? (a_q[15] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign s_d    = raw;
`endif
    assign zero_d = (s_d == 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            beff_q    <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_q       <= '0;
            ovfl_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        a_q     <= A;
                        // B is pre-inverted here and carry seeded with sub for the +1.
                        beff_q  <= sub ? ~B : B;
                        carry_q <= sub;
                        cnt_q   <= 2'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    carry_q <= nib_c;
                    cnt_q   <= cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    partial_q[3:0]  <= nib_s;
                        2'd1:    partial_q[7:4]  <= nib_s;
                        2'd2:    partial_q[11:8] <= nib_s;
                        default: ;
                    endcase
                    if (cnt_q == LAST_NIB) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_q     <= s_d;
                        ovfl_q  <= ovfl_d;
                        zero_q  <= zero_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign ovfl = ovfl_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Randomized and directed bench for nibble_addsub_seq against an integer-arithmetic reference.
module tb_nibble_addsub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        ovfl;
    logic        zero;

    int n_chk  = 0;
    int n_fail = 0;

    nibble_addsub_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .ovfl  (ovfl),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] exp_s, output logic exp_ov, output logic exp_z);
        int ia;
        int ib;
        int r;
        ia = int'($signed(a));
        ib = int'($signed(b));
        r  = s ? (ia - ib) : (ia + ib);
        exp_ov = (r > 32767) || (r < -32768);
        exp_s  = r[15:0];
`ifdef NIBBLE_ADDSUB_SATURATE_EN
        if (exp_ov) exp_s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        exp_z = (exp_s == 16'h0000);
    endtask

    // Called at #1 after an active edge with the DUT in IDLE or DONE.
    // poke: keep start high with different operands during the first CALC cycles.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input bit poke);
        logic [15:0] es;
        logic        eo;
        logic        ez;
        int          lat;
        model(a, b, s, es, eo, ez);
        start = 1'b1; A = a; B = b; sub = s;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
        check({tag, "_busy_rise"}, busy, 1);
        lat = 0;
        while (!done && lat < 10) begin
            if (poke && lat < 2) begin
                start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (!done && lat < 4) check({tag, "_busy_calc"}, busy, 1);
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 4);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_S"}, S, es);
        check({tag, "_ovfl"}, ovfl, eo);
        check({tag, "_zero"}, zero, ez);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_S", S, 16'h0000);
        check("rst_ovfl", ovfl, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0);
        idle_cycle();
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_cycle();
        do_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0);
        idle_cycle();
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
        idle_cycle();
        do_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b0);
        idle_cycle();

        // start during CALC is ignored; restart in the DONE cycle runs immediately
        do_op("ign_start", 16'h0001, 16'h0001, 1'b0, 1'b1);
        check("ign_start_S_exact", S, 16'h0002);
        do_op("b2b", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        check("b2b_S_exact", S, 16'hFFFE);
        idle_cycle();

        // Reset after E2 discards the operation
        start = 1'b1; A = 16'h4321; B = 16'h1234; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_S", S, 16'h0000);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ovfl", ovfl, 0);
        check("midrst_zero", zero, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
        end
        do_op("post_rst", 16'h4321, 16'h1234, 1'b0, 1'b0);
        idle_cycle();

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = {ra[15], {15{~ra[15]}}};
            do_op("rand", ra, rb, 1'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
